// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// the bus read/write select levels.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PC_OUT  = 3'd1,
    MEM_REQ = 3'd2,
    IR_LOAD = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } fetch_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating counter of memory-request cycles; flags the cycle on which the
// request has gone unanswered for WAIT_MAX cycles.
module fetch_wait_timer #(
  parameter int WAIT_MAX = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] SAT  = CW'(WAIT_MAX);

  logic [CW-1:0] count;

  // Holds at WAIT_MAX rather than wrapping so a stalled request cannot alias
  // back to an early count.
  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (enable && (count != SAT))
      count <= count + CW'(1);
  end

  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control stage: moves the PC to the MAR, reads memory into IR and
// bumps the PC, one fetch per start request; it only ever samples the bus.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             pc_enable,
  output logic             pc_rw,
  output logic             pc_count,
  output logic             mar_load,
  output logic             mem_enable,
  output logic             mem_rw,
  output logic [WIDTH-1:0] ir,
  output logic             busy,
  output logic             done,
  output logic             error
);

  fetch_state_t state, next_state;
  logic         timed_out;

  fetch_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != MEM_REQ),
    .enable (state == MEM_REQ),
    .expired(timed_out)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // The word is taken on the edge that leaves MEM_REQ, so it is visible in IR_LOAD.
  always_ff @(posedge clock) begin
    if (reset)
      ir <= '0;
    else if ((state == MEM_REQ) && mem_ready)
      ir <= data_in;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = PC_OUT;
      PC_OUT:  next_state = MEM_REQ;
      MEM_REQ: begin
        if (mem_ready)
          next_state = IR_LOAD;
        else if (timed_out)
          next_state = FAULT;
      end
      IR_LOAD: next_state = DONE;
      DONE:    next_state = start ? PC_OUT : IDLE;
      FAULT:   if (clear) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore decode; read stays the resting select level on both buses.
  always_comb begin
    pc_enable  = 1'b0;
    pc_rw      = RW_READ;
    pc_count   = 1'b0;
    mar_load   = 1'b0;
    mem_enable = 1'b0;
    mem_rw     = RW_READ;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      PC_OUT: begin
        pc_enable = 1'b1;
        mar_load  = 1'b1;
        busy      = 1'b1;
      end
      MEM_REQ: begin
        mem_enable = 1'b1;
        busy       = 1'b1;
      end
      IR_LOAD: begin
        pc_count = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      FAULT:   error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, corner-case
// sequences, then random traffic against a timeline-based reference model.
module tb_fetch_sequencer;

  localparam int WIDTH    = 16;
  localparam int WAIT_MAX = 8;

  // {pc_enable, pc_rw, pc_count, mar_load, mem_enable, mem_rw, busy, done, error}
  localparam logic [8:0] C_IDLE  = 9'b010001000;
  localparam logic [8:0] C_PCOUT = 9'b110101100;
  localparam logic [8:0] C_MEM   = 9'b010011100;
  localparam logic [8:0] C_IRLD  = 9'b011001100;
  localparam logic [8:0] C_DONE  = 9'b010001110;
  localparam logic [8:0] C_FAULT = 9'b010001001;

  typedef struct {
    logic             rst;
    logic             st;
    logic             clr;
    logic             rdy;
    logic [WIDTH-1:0] data;
    logic [8:0]       ctrl;
    logic [WIDTH-1:0] ir;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             mem_ready = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             pc_enable, pc_rw, pc_count, mar_load, mem_enable, mem_rw;
  logic             busy, done, error;
  logic [WIDTH-1:0] ir;
  logic [8:0]       actCtrl;

  int compared   = 0;
  int mismatched = 0;

  int               mSince;
  int               mReadyAt;
  bit               mFault;
  logic [WIDTH-1:0] mIr;

  vec_t vecs[14];

  fetch_sequencer #(
    .WIDTH   (WIDTH),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .mem_ready (mem_ready),
    .data_in   (data_in),
    .pc_enable (pc_enable),
    .pc_rw     (pc_rw),
    .pc_count  (pc_count),
    .mar_load  (mar_load),
    .mem_enable(mem_enable),
    .mem_rw    (mem_rw),
    .ir        (ir),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  assign actCtrl = {pc_enable, pc_rw, pc_count, mar_load, mem_enable, mem_rw, busy, done, error};

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic s, input logic c, input logic m,
                               input logic [WIDTH-1:0] d);
    reset     = r;
    start     = s;
    clear     = c;
    mem_ready = m;
    data_in   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] expCtrl,
                             input logic [WIDTH-1:0] expIr);
    compared++;
    if (actCtrl !== expCtrl) begin
      mismatched++;
      $display("[TB] FAIL %s ctrl actual=%b required=%b", name, actCtrl, expCtrl);
    end
    compared++;
    if (ir !== expIr) begin
      mismatched++;
      $display("[TB] FAIL %s ir actual=%h required=%h", name, ir, expIr);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model view: a fetch is a timeline counted from its PC_OUT cycle; data
  // arrival time fixes where the IR_LOAD and DONE cycles fall.
  function automatic logic [8:0] modelCtrl();
    if (mFault)                    return C_FAULT;
    if (mSince == 0)               return C_IDLE;
    if (mSince == 1)               return C_PCOUT;
    if (mReadyAt == 0)             return C_MEM;
    if (mSince == mReadyAt + 1)    return C_IRLD;
    return C_DONE;
  endfunction

  task automatic modelStep(input logic r, input logic s, input logic c, input logic m,
                           input logic [WIDTH-1:0] d);
    if (r) begin
      mSince = 0; mReadyAt = 0; mFault = 0; mIr = '0;
    end else if (mFault) begin
      if (c) mFault = 0;
    end else if (mSince == 0) begin
      if (s) mSince = 1;
    end else if (mSince >= 2 && mReadyAt == 0) begin
      if (m) begin
        mIr = d; mReadyAt = mSince; mSince++;
      end else if (mSince - 1 == WAIT_MAX) begin
        mFault = 1; mSince = 0;
      end else begin
        mSince++;
      end
    end else if (mReadyAt != 0 && mSince == mReadyAt + 2) begin
      mReadyAt = 0;
      mSince   = s ? 1 : 0;
    end else begin
      mSince++;
    end
  endtask

  initial begin
    int memCycles, pcCounts, dones, lastDone;
    logic r, s, c, m;
    logic [WIDTH-1:0] d;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, C_IDLE,  16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hA5A5, C_PCOUT, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, C_MEM,   16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, C_IRLD,  16'hA5A5};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, C_DONE,  16'hA5A5};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, C_IDLE,  16'hA5A5};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, C_PCOUT, 16'hA5A5};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, C_MEM,   16'hA5A5};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, C_MEM,   16'hA5A5};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, C_MEM,   16'hA5A5};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, C_MEM,   16'hA5A5};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, C_IRLD,  16'h1234};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hEEEE, C_DONE,  16'h1234};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hEEEE, C_IDLE,  16'h1234};

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].clr, vecs[i].rdy, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].ir);
    end

    $display("[TB] timeout to fault, then clear");
    applyStimulus(0, 1, 0, 0, 16'hFFFF);
    memCycles = 0;
    pcCounts  = 0;
    for (int i = 0; i < 30 && !error; i++) begin
      if (mem_enable) memCycles++;
      if (pc_count)   pcCounts++;
      applyStimulus(0, 0, 0, 0, 16'hFFFF);
    end
    checkOutput("fault_entered", C_FAULT, 16'h1234);
    checkValue("fault_mem_cycles", memCycles, WAIT_MAX);
    checkValue("fault_pc_count", pcCounts, 0);
    applyStimulus(0, 1, 0, 1, 16'hFFFF);
    checkOutput("fault_ignores_start", C_FAULT, 16'h1234);
    applyStimulus(0, 0, 1, 0, 16'hFFFF);
    checkOutput("fault_cleared", C_IDLE, 16'h1234);

    $display("[TB] back-to-back fetches");
    pcCounts = 0;
    dones    = 0;
    lastDone = -1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, dones < 3, 0, 1, 16'(pcCounts + 1));
      if (pc_count) pcCounts++;
      if (done) begin
        if (dones > 0) checkValue("b2b_done_gap", i - lastDone, 4);
        lastDone = i;
        dones++;
      end else if (dones == 3) begin
        break;
      end
    end
    checkValue("b2b_dones", dones, 3);
    checkValue("b2b_pc_counts", pcCounts, 3);
    checkOutput("b2b_end", C_IDLE, 16'h0003);

    $display("[TB] reset in second memory request cycle");
    applyStimulus(0, 1, 0, 0, 16'hBEEF);
    applyStimulus(0, 0, 0, 0, 16'hBEEF);
    applyStimulus(0, 0, 0, 0, 16'hBEEF);
    checkOutput("rst_mid_mem2", C_MEM, 16'h0003);
    applyStimulus(1, 1, 0, 1, 16'hBEEF);
    checkOutput("rst_mid_after", C_IDLE, 16'h0000);
    applyStimulus(0, 1, 0, 1, 16'h0BEE);
    checkOutput("rst_restart_pc", C_PCOUT, 16'h0000);
    applyStimulus(0, 0, 0, 1, 16'h0BEE);
    applyStimulus(0, 0, 0, 1, 16'h0BEE);
    checkOutput("rst_restart_ir", C_IRLD, 16'h0BEE);
    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("rst_restart_done", C_DONE, 16'h0BEE);
    applyStimulus(0, 0, 0, 0, 16'h0000);

    $display("[TB] data arrives on the timeout edge");
    applyStimulus(0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < WAIT_MAX; i++) applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("race_last_mem", C_MEM, 16'h0BEE);
    applyStimulus(0, 0, 0, 1, 16'hC0DE);
    checkOutput("race_ir_load", C_IRLD, 16'hC0DE);
    applyStimulus(0, 0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("race_idle", C_IDLE, 16'hC0DE);

    $display("[TB] random traffic against model");
    modelStep(1, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("rand_reset", modelCtrl(), mIr);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      s = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 2) == 0);
      d = 16'($urandom);
      modelStep(r, s, c, m, d);
      applyStimulus(r, s, c, m, d);
      checkOutput("random", modelCtrl(), mIr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
